// File: rtl/reg_bank_loader.sv
// Purpose : streams 16-bit words into consecutive entries of a 64 x 16 register bank, one frame per start.
// Latency : a word accepted at a clock edge appears on Reg_Outs right after that edge (registered write).
// Backpressure: in_ready is high only in LOAD. No word is taken in IDLE or DONE, and starts arriving outside IDLE are dropped.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start               - frame start command (IDLE only); base_addr / load_len sampled with it
//   in_valid/in_data    - word stream; in_ready - word accepted when in_valid & in_ready
//   Reg_Outs            - flattened bank, entry i at [DATA_W*i +: DATA_W]
//   wr_ptr              - entry the next accepted word goes to
//   busy / done         - busy in LOAD and DONE; done is a one-cycle end-of-frame pulse
module reg_bank_loader #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6        // must be log2(DEPTH): wr_ptr wraps by overflow
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [ADDR_W:0]           load_len,
   input  logic                      in_valid,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      in_ready,
   output logic [DEPTH*DATA_W-1:0]   Reg_Outs,
   output logic [ADDR_W-1:0]         wr_ptr,
   output logic                      busy,
   output logic                      done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE = 1;

   logic [1:0]              state_q, state_d;
   logic [DEPTH*DATA_W-1:0] bank_q, bank_d;
   logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]         cnt_q, cnt_d;
   logic [ADDR_W:0]         len_q, len_d;
   logic [ADDR_W:0]         len_clamped;

   always_comb begin
      state_d     = state_q;
      bank_d      = bank_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      // Oversized requests load the whole bank once rather than wrapping onto themselves.
      len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;

      case (state_q)
         ST_IDLE: begin
            // A zero-length start would finish without a word; it is dropped instead.
            if (start && (load_len != '0)) begin
               len_d    = len_clamped;
               wr_ptr_d = base_addr;
               cnt_d    = '0;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // in_ready is implied by being in LOAD, so in_valid alone marks an accept.
            if (in_valid) begin
               bank_d[int'(wr_ptr_q)*DATA_W +: DATA_W] = in_data;
               wr_ptr_d = wr_ptr_q + PTR_ONE;   // natural overflow gives the modulo-DEPTH wrap
               cnt_d    = cnt_q + CNT_ONE;
               if (cnt_d == len_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         bank_q   <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
      end
   end

   assign in_ready = (state_q == ST_LOAD);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign Reg_Outs = bank_q;
   assign wr_ptr   = wr_ptr_q;

endmodule

// File: tb/tb_reg_bank_loader.sv
module tb_reg_bank_loader;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [5:0]    base_addr;
   logic [6:0]    load_len;
   logic          in_valid;
   logic [15:0]   in_data;
   logic          in_ready;
   logic [1023:0] reg_outs;
   logic [5:0]    wr_ptr;
   logic          busy;
   logic          done;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_bank_loader #(.DATA_W(16), .DEPTH(64), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .load_len(load_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .Reg_Outs(reg_outs),
      .wr_ptr(wr_ptr), .busy(busy), .done(done)
   );

   // Reference model: frame bookkeeping as "words still owed" plus a pending done flag.
   logic [15:0] m_bank [64];
   int          m_ptr;
   int          m_rem;
   bit          m_done;
   bit          acc_seen;    // DUT took a word at the last edge (observed from in_ready before the edge)

   function automatic logic [15:0] entry(input logic [1023:0] b, input int i);
      return b[i*16 +: 16];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_bank[i] = 16'h0;
      m_ptr  = 0;
      m_rem  = 0;
      m_done = 0;
   endtask

   task automatic model_edge(input logic r, input logic s, input logic [5:0] b,
                             input logic [6:0] l, input logic v, input logic [15:0] d);
      if (r) begin
         model_reset();
      end else if (m_rem > 0) begin
         if (v) begin
            m_bank[m_ptr] = d;
            m_ptr = (m_ptr + 1) % 64;
            m_rem--;
            if (m_rem == 0) m_done = 1;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (s && l != 0) begin
         m_rem = (int'(l) > 64) ? 64 : int'(l);
         m_ptr = int'(b);
      end
   endtask

   task automatic model_check();
      int bad;
      chk("in_ready", 32'(in_ready), 32'(m_rem > 0));
      chk("busy",     32'(busy),     32'((m_rem > 0) || m_done));
      chk("done",     32'(done),     32'(m_done));
      chk("wr_ptr",   32'(wr_ptr),   32'(m_ptr));
      bad = -1;
      for (int i = 0; i < 64; i++)
         if (bad < 0 && entry(reg_outs, i) !== m_bank[i]) bad = i;
      n_chk++;
      if (bad >= 0) begin
         n_err++;
         $display("FAIL bank entry %0d: got 0x%0h, expected 0x%0h at %0t",
                  bad, entry(reg_outs, bad), m_bank[bad], $time);
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare against the model away from the edge.
   task automatic step(input logic r, input logic s, input logic [5:0] b,
                       input logic [6:0] l, input logic v, input logic [15:0] d);
      rst = r; start = s; base_addr = b; load_len = l; in_valid = v; in_data = d;
      acc_seen = in_ready & v;
      @(posedge clk);
      model_edge(r, s, b, l, v, d);
      @(negedge clk);
      model_check();
   endtask

   typedef struct {
      logic        r, s;
      logic [5:0]  b;
      logic [6:0]  l;
      logic        v;
      logic [15:0] d;
      logic        e_rdy, e_busy, e_done;
      logic [5:0]  e_ptr;
   } vec_t;

   vec_t vecs [12];
   int   accepts;
   bit   seen;

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; load_len = '0; in_valid = 1'b0; in_data = '0;
      acc_seen = 1'b0;
      model_reset();

      // Wrap-around frame, bubbles, start ignored in LOAD and DONE, zero-length start, one-word frame.
      //          r  s  base len v  data      rdy busy done ptr
      vecs[0]  = '{1, 0, 0,  0,  0, 16'h0,   0, 0, 0, 0};
      vecs[1]  = '{0, 1, 62, 4,  1, 16'h00A0, 1, 1, 0, 62};
      vecs[2]  = '{0, 0, 0,  0,  1, 16'h00A0, 1, 1, 0, 63};
      vecs[3]  = '{0, 0, 0,  0,  0, 16'hDEAD, 1, 1, 0, 63};
      vecs[4]  = '{0, 1, 5,  2,  1, 16'h00A1, 1, 1, 0, 0};
      vecs[5]  = '{0, 0, 0,  0,  1, 16'h00A2, 1, 1, 0, 1};
      vecs[6]  = '{0, 0, 0,  0,  1, 16'h00A3, 0, 1, 1, 2};
      vecs[7]  = '{0, 1, 10, 3,  1, 16'h00FF, 0, 0, 0, 2};
      vecs[8]  = '{0, 1, 7,  0,  1, 16'h00EE, 0, 0, 0, 2};
      vecs[9]  = '{0, 1, 3,  1,  0, 16'h0,   1, 1, 0, 3};
      vecs[10] = '{0, 0, 0,  0,  1, 16'h0055, 0, 1, 1, 4};
      vecs[11] = '{0, 0, 0,  0,  1, 16'h0077, 0, 0, 0, 4};

      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].l, vecs[i].v, vecs[i].d);
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("vec%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
         chk($sformatf("vec%0d done", i),     32'(done),     32'(vecs[i].e_done));
         chk($sformatf("vec%0d wr_ptr", i),   32'(wr_ptr),   32'(vecs[i].e_ptr));
      end
      chk("vec entry62", 32'(entry(reg_outs, 62)), 32'h00A0);
      chk("vec entry63", 32'(entry(reg_outs, 63)), 32'h00A1);
      chk("vec entry0",  32'(entry(reg_outs, 0)),  32'h00A2);
      chk("vec entry1",  32'(entry(reg_outs, 1)),  32'h00A3);
      chk("vec entry2",  32'(entry(reg_outs, 2)),  32'h0000);
      chk("vec entry3",  32'(entry(reg_outs, 3)),  32'h0055);

      // Full 64-word frame from entry 0, in_valid held high.
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 64, 0, 0);
      accepts = 0;
      for (int i = 0; i < 64; i++) begin
         step(0, 0, 0, 0, 1, 16'(i + 1));
         if (acc_seen) accepts++;
         if (i == 62) chk("full done early", 32'(done), 32'h0);
      end
      chk("full accepts", 32'(accepts), 32'd64);
      chk("full done", 32'(done), 32'h1);
      chk("full entry0", 32'(reg_outs[15:0]), 32'h0001);
      chk("full entry63", 32'(reg_outs[1023:1008]), 32'h0040);
      chk("full wr_ptr", 32'(wr_ptr), 32'h0);
      step(0, 0, 0, 0, 1, 16'hBEEF);
      chk("full idle after done", 32'(done), 32'h0);

      // Wrap frame over a populated bank: entry 2 keeps its earlier value.
      step(0, 1, 62, 4, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 16'(16'h00A0 + i));
      step(0, 0, 0, 0, 0, 0);
      chk("wrap entry62", 32'(entry(reg_outs, 62)), 32'h00A0);
      chk("wrap entry1",  32'(entry(reg_outs, 1)),  32'h00A3);
      chk("wrap entry2",  32'(entry(reg_outs, 2)),  32'h0003);
      chk("wrap wr_ptr",  32'(wr_ptr), 32'h2);

      // Toggling in_valid: 3 accepts among 1,0,0,1,0,1.
      step(0, 1, 20, 3, 0, 0);
      step(0, 0, 0, 0, 1, 16'h0101);
      step(0, 0, 0, 0, 0, 16'h0202);
      step(0, 0, 0, 0, 0, 16'h0303);
      step(0, 0, 0, 0, 1, 16'h0404);
      step(0, 0, 0, 0, 0, 16'h0505);
      chk("toggle done early", 32'(done), 32'h0);
      step(0, 0, 0, 0, 1, 16'h0606);
      chk("toggle done", 32'(done), 32'h1);
      chk("toggle ready in DONE", 32'(in_ready), 32'h0);
      step(0, 0, 0, 0, 1, 16'h0707);
      chk("toggle ready in IDLE", 32'(in_ready), 32'h0);
      chk("toggle entry22", 32'(entry(reg_outs, 22)), 32'h0606);
      chk("toggle entry23", 32'(entry(reg_outs, 23)), 32'h0018);

      // Oversized length is clamped to 64 words.
      step(0, 1, 9, 100, 0, 0);
      accepts = 0;
      seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         step(0, 0, 0, 0, 1, 16'($urandom));
         if (acc_seen) accepts++;
         if (done) seen = 1;
      end
      chk("clamp done seen", 32'(seen), 32'h1);
      chk("clamp accepts", 32'(accepts), 32'd64);
      chk("clamp wr_ptr", 32'(wr_ptr), 32'd9);

      // Reset after 10 of 20 words: frame abandoned, bank cleared, no done.
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 30, 20, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 16'(16'h1000 + i));
      step(1, 0, 0, 0, 1, 16'hFFFF);
      chk("midrst zero bus", 32'(reg_outs == '0), 32'h1);
      chk("midrst in_ready", 32'(in_ready), 32'h0);
      chk("midrst wr_ptr", 32'(wr_ptr), 32'h0);
      chk("midrst done", 32'(done), 32'h0);
      step(0, 0, 0, 0, 1, 16'hFFFF);
      chk("midrst done later", 32'(done), 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 5) == 0,
              6'($urandom),
              7'($urandom_range(0, 127)),
              $urandom_range(0, 2) != 0,
              16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
